// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD command sequencer: state and transfer
// encodings, timing constants, command codes, the lcd_din field layout
// and the fixed init ROM.
package lcd_pkg;

   // Timing at 22.1184 MHz
   localparam logic [18:0] PWRUP_CYC = 19'd331776;  // 15 ms power-up wait
   localparam logic [16:0] DLY_SHORT = 17'd885;     // 40 us ordinary write
   localparam logic [16:0] DLY_LONG  = 17'd36275;   // 1.64 ms clear / home

   // Panel geometry: 16x2
   localparam int unsigned COLS = 16;

   // HD44780 command codes used by the sequencer
   localparam logic [7:0] CMD_CLEAR = 8'h01;
   localparam logic [7:0] CMD_HOME  = 8'h02;
   localparam logic [7:0] CMD_LINE0 = 8'h80;
   localparam logic [7:0] CMD_LINE1 = 8'hC0;

   // Init sequence length and index of its last entry
   localparam int unsigned INIT_LEN  = 4;
   localparam logic [1:0]  INIT_LAST = 2'(INIT_LEN - 1);

   typedef enum logic [2:0] {
      ST_PWRUP,
      ST_INIT,
      ST_IDLE,
      ST_SEND,
      ST_WAIT,
      ST_WRAP
   } state_t;

   // What the transfer currently in flight was issued for
   typedef enum logic [1:0] {
      XF_INIT,
      XF_HOST,
      XF_WRAP
   } xfer_t;

   // lcd_din layout: [25:9] post-write delay, [8] rs, [7:0] data
   typedef struct packed {
      logic [16:0] delay;
      logic        rs;
      logic [7:0]  data;
   } din_t;

   // Clear and home need the long post-write delay; everything else is short
   function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
      return !rs && ((data == CMD_CLEAR) || (data == CMD_HOME));
   endfunction

   function automatic din_t make_din(input logic [16:0] delay, input logic rs,
                                     input logic [7:0] data);
      din_t d;
      d.delay = delay;
      d.rs    = rs;
      d.data  = data;
      return d;
   endfunction

   // Init ROM, {rs, data}: function set, display on, clear, entry mode
   function automatic logic [8:0] init_rom(input logic [1:0] idx);
      logic [8:0] entry;
      case (idx)
         2'd0:    entry = {1'b0, 8'h38};
         2'd1:    entry = {1'b0, 8'h0C};
         2'd2:    entry = {1'b0, CMD_CLEAR};
         default: entry = {1'b0, 8'h06};
      endcase
      return entry;
   endfunction

endpackage

// File: rtl/lcd_sequencer_cursor.sv
// Cursor tracker for a 16x2 panel: column counter with line toggle on
// wrap, absolute load from a set-DDRAM-address command, and clear.
module lcd_cursor
   import lcd_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,        // cursor to line 0, col 0
   input  logic       load,       // absolute position from DDRAM command
   input  logic       load_line,
   input  logic [3:0] load_col,
   input  logic       inc,        // one character written
   output logic       line,
   output logic [3:0] col,
   output logic       at_eol      // next increment wraps to the other line
);

   localparam logic [3:0] COL_LAST = 4'(COLS - 1);

   assign at_eol = (col == COL_LAST);

   // Position register; clear beats load beats increment
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         line <= 1'b0;
         col  <= '0;
      end else if (clr) begin
         line <= 1'b0;
         col  <= '0;
      end else if (load) begin
         line <= load_line;
         col  <= load_col;
      end else if (inc) begin
         if (at_eol) begin
            line <= ~line;
            col  <= '0;
         end else begin
            col <= col + 4'd1;
         end
      end
   end

endmodule

// File: rtl/lcd_sequencer.sv
// LCD command sequencer: power-up wait, fixed init sequence, then
// forwards host command/character requests to the write engine with the
// right post-write delay, inserting a line-address command at line end.
module lcd_sequencer
   import lcd_pkg::*;
#(
   parameter logic [18:0] PWRUP_CYC = lcd_pkg::PWRUP_CYC,
   parameter logic [16:0] DLY_SHORT = lcd_pkg::DLY_SHORT,
   parameter logic [16:0] DLY_LONG  = lcd_pkg::DLY_LONG
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        req_rs,
   input  logic [7:0]  req_data,
   output logic        ready,
   output logic        init_done,
   output logic        lcd_intr,
   output logic [25:0] lcd_din,
   input  logic        lcd_ok
);

   state_t      state;
   xfer_t       xfer;
   logic [18:0] pwr_cnt;
   logic [1:0]  init_idx;
   din_t        din_q;
   logic [8:0]  rom_entry;

   logic        xfer_done;
   logic        cur_clr;
   logic        cur_load;
   logic        cur_inc;
   logic        cur_line;
   logic [3:0]  cur_col;
   logic        cur_at_eol;

   assign lcd_din   = din_q;
   assign rom_entry = init_rom(init_idx);

   // Cursor update strobes, decoded from the transfer that just completed
   always_comb begin
      // NOTE: every output gets a default first so no path infers a latch.
      cur_clr  = 1'b0;
      cur_load = 1'b0;
      cur_inc  = 1'b0;
      xfer_done = (state == ST_WAIT) && lcd_ok;
      if (xfer_done) begin
         case (xfer)
            XF_INIT: cur_clr = (init_idx == INIT_LAST);
            XF_HOST: begin
               if (din_q.rs) begin
                  cur_inc = 1'b1;
               end else if (is_long_cmd(din_q.rs, din_q.data)) begin
                  cur_clr = 1'b1;
               end else if (din_q.data[7]) begin
                  cur_load = 1'b1;
               end
            end
            default: ;  // line-address write: cursor already updated
         endcase
      end
   end

   lcd_cursor u_cursor (
      .clk       (clk),
      .rst       (rst),
      .clr       (cur_clr),
      .load      (cur_load),
      .load_line (din_q.data[6]),
      .load_col  (din_q.data[3:0]),
      .inc       (cur_inc),
      .line      (cur_line),
      .col       (cur_col),
      .at_eol    (cur_at_eol)
   );

   // Sequencer FSM with registered handshake outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_PWRUP;
         xfer      <= XF_INIT;
         pwr_cnt   <= '0;
         init_idx  <= '0;
         din_q     <= '0;
         ready     <= 1'b0;
         init_done <= 1'b0;
         lcd_intr  <= 1'b0;
      end else begin
         // NOTE: non-blocking throughout; lcd_intr defaults low so it is a
         // single-cycle pulse that rises only on entry to SEND.
         lcd_intr <= 1'b0;
         case (state)
            ST_PWRUP: begin
               if (pwr_cnt == PWRUP_CYC - 19'd1) begin
                  init_idx <= '0;
                  state    <= ST_INIT;
               end else begin
                  pwr_cnt <= pwr_cnt + 19'd1;
               end
            end

            ST_INIT: begin
               din_q    <= make_din(is_long_cmd(rom_entry[8], rom_entry[7:0]) ? DLY_LONG : DLY_SHORT,
                                    rom_entry[8], rom_entry[7:0]);
               xfer     <= XF_INIT;
               lcd_intr <= 1'b1;
               state    <= ST_SEND;
            end

            ST_IDLE: begin
               if (req) begin
                  din_q    <= make_din(is_long_cmd(req_rs, req_data) ? DLY_LONG : DLY_SHORT,
                                       req_rs, req_data);
                  xfer     <= XF_HOST;
                  ready    <= 1'b0;
                  lcd_intr <= 1'b1;
                  state    <= ST_SEND;
               end
            end

            ST_SEND: begin
               state <= ST_WAIT;
            end

            ST_WAIT: begin
               // din_q is held untouched here: the engine reads it until ok
               if (lcd_ok) begin
                  case (xfer)
                     XF_INIT: begin
                        if (init_idx == INIT_LAST) begin
                           init_done <= 1'b1;
                           ready     <= 1'b1;
                           state     <= ST_IDLE;
                        end else begin
                           init_idx <= init_idx + 2'd1;
                           state    <= ST_INIT;
                        end
                     end
                     XF_HOST: begin
                        if (din_q.rs && cur_at_eol) begin
                           state <= ST_WRAP;
                        end else begin
                           ready <= 1'b1;
                           state <= ST_IDLE;
                        end
                     end
                     default: begin
                        ready <= 1'b1;
                        state <= ST_IDLE;
                     end
                  endcase
               end
            end

            ST_WRAP: begin
               // Cursor has already toggled line, so address the new line
               din_q    <= make_din(DLY_SHORT, 1'b0, cur_line ? CMD_LINE1 : CMD_LINE0);
               xfer     <= XF_WRAP;
               lcd_intr <= 1'b1;
               state    <= ST_SEND;
            end

            default: begin
               state <= ST_PWRUP;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_sequencer.sv
// Directed self-checking bench for lcd_sequencer. The bench plays the
// write engine: it waits for lcd_intr, checks lcd_din, then returns a
// one-cycle lcd_ok a few cycles later.
`timescale 1ns/1ps
module tb_lcd_sequencer;

   localparam logic [18:0] TB_PWRUP = 19'd40;
   localparam logic [16:0] S = 17'd885;
   localparam logic [16:0] L = 17'd36275;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req = 1'b0;
   logic        req_rs = 1'b0;
   logic [7:0]  req_data = 8'h00;
   logic        lcd_ok = 1'b0;
   logic        ready;
   logic        init_done;
   logic        lcd_intr;
   logic [25:0] lcd_din;

   int n_checks = 0;
   int n_fail   = 0;

   lcd_sequencer #(.PWRUP_CYC(TB_PWRUP)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .req_rs    (req_rs),
      .req_data  (req_data),
      .ready     (ready),
      .init_done (init_done),
      .lcd_intr  (lcd_intr),
      .lcd_din   (lcd_din),
      .lcd_ok    (lcd_ok)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic wait_intr(input string tag, output int waited);
      waited = 0;
      while (lcd_intr !== 1'b1 && waited < 64) begin
         tick();
         waited++;
      end
      if (lcd_intr !== 1'b1) check({tag, " intr timeout"}, lcd_intr, 1);
   endtask

   // Engine side of one write: expects lcd_intr after exp_wait more cycles
   task automatic engine_cycle(input string tag, input logic [25:0] exp_din, input int exp_wait);
      int w;
      wait_intr(tag, w);
      check({tag, " latency"}, w, exp_wait);
      check({tag, " din"}, lcd_din, exp_din);
      check({tag, " ready low"}, ready, 0);
      tick();
      check({tag, " intr pulse"}, lcd_intr, 0);
      tick();
      tick();
      check({tag, " din hold"}, lcd_din, exp_din);
      lcd_ok = 1'b1;
      req    = 1'b0;
      tick();
      lcd_ok = 1'b0;
   endtask

   // Host request, engine completion and optional automatic line write
   task automatic host_xfer(input string tag, input logic rs, input logic [7:0] data,
                            input logic [16:0] dly, input logic [7:0] wrap_code,
                            input logic hold);
      check({tag, " ready before"}, ready, 1);
      req      = 1'b1;
      req_rs   = rs;
      req_data = data;
      tick();
      if (!hold) req = 1'b0;
      engine_cycle(tag, {dly, rs, data}, 0);
      if (wrap_code != 8'h00) begin
         check({tag, " ready in wrap"}, ready, 0);
         engine_cycle({tag, " wrap"}, {S, 1'b0, wrap_code}, 1);
      end
      check({tag, " ready after ok"}, ready, 1);
      check({tag, " no extra intr"}, lcd_intr, 0);
   endtask

   task automatic check_cursor(input string tag, input logic line, input logic [3:0] col);
      check({tag, " line"}, dut.cur_line, line);
      check({tag, " col"}, dut.cur_col, col);
   endtask

   // Power-up wait and the four init writes, starting at the negedge rst fell
   task automatic run_init(input string tag);
      int k = 0;
      while (lcd_intr !== 1'b1 && k < int'(TB_PWRUP) + 20) begin
         tick();
         k++;
         lcd_ok = (k == 2);  // engine's ok as it leaves reset: must be ignored
         if (k == 5) check({tag, " ready in pwrup"}, ready, 0);
      end
      lcd_ok = 1'b0;
      check({tag, " first intr cycle"}, k, int'(TB_PWRUP) + 1);
      engine_cycle({tag, " 0x38"}, {S, 1'b0, 8'h38}, 0);
      check({tag, " init_done early"}, init_done, 0);
      engine_cycle({tag, " 0x0C"}, {S, 1'b0, 8'h0C}, 1);
      engine_cycle({tag, " 0x01"}, {L, 1'b0, 8'h01}, 1);
      engine_cycle({tag, " 0x06"}, {S, 1'b0, 8'h06}, 1);
      check({tag, " init_done"}, init_done, 1);
      check({tag, " ready"}, ready, 1);
      check_cursor({tag, " cursor"}, 1'b0, 4'd0);
   endtask

   initial begin
      int w;
      // Reset state
      tick();
      check("rst ready", ready, 0);
      check("rst init_done", init_done, 0);
      check("rst intr", lcd_intr, 0);
      check("rst din", lcd_din, 0);
      rst = 1'b0;
      run_init("init");

      // Single character
      host_xfer("char 0x41", 1'b1, 8'h41, S, 8'h00, 1'b0);
      check_cursor("after 0x41", 1'b0, 4'd1);

      // req held high through the whole transfer is accepted once
      host_xfer("held req", 1'b1, 8'h42, S, 8'h00, 1'b1);
      check_cursor("after held", 1'b0, 4'd2);

      // Spurious ok in IDLE is ignored
      lcd_ok = 1'b1;
      tick();
      lcd_ok = 1'b0;
      tick();
      check("idle ok ready", ready, 1);
      check("idle ok intr", lcd_intr, 0);
      check_cursor("idle ok", 1'b0, 4'd2);

      // Home, then two full lines
      host_xfer("home", 1'b0, 8'h02, L, 8'h00, 1'b0);
      check_cursor("after home", 1'b0, 4'd0);
      for (int i = 0; i < 16; i++)
         host_xfer("line0 char", 1'b1, 8'h30 + 8'(i), S, (i == 15) ? 8'hC0 : 8'h00, 1'b0);
      check_cursor("after line0", 1'b1, 4'd0);
      for (int i = 0; i < 16; i++)
         host_xfer("line1 char", 1'b1, 8'h61 + 8'(i), S, (i == 15) ? 8'h80 : 8'h00, 1'b0);
      check_cursor("after line1", 1'b0, 4'd0);

      // Clear mid-line
      for (int i = 0; i < 5; i++)
         host_xfer("pre-clear char", 1'b1, 8'h58, S, 8'h00, 1'b0);
      check_cursor("before clear", 1'b0, 4'd5);
      host_xfer("clear", 1'b0, 8'h01, L, 8'h00, 1'b0);
      check_cursor("after clear", 1'b0, 4'd0);
      for (int i = 0; i < 16; i++)
         host_xfer("post-clear char", 1'b1, 8'h41, S, (i == 15) ? 8'hC0 : 8'h00, 1'b0);

      // Set DDRAM address: line 1, col 5; 11 characters reach line end
      host_xfer("ddram 0xC5", 1'b0, 8'hC5, S, 8'h00, 1'b0);
      check_cursor("after 0xC5", 1'b1, 4'd5);
      for (int i = 0; i < 11; i++)
         host_xfer("from c5 char", 1'b1, 8'h7A, S, (i == 10) ? 8'h80 : 8'h00, 1'b0);
      check_cursor("after c5 run", 1'b0, 4'd0);

      // Ordinary command leaves the cursor alone
      host_xfer("c char", 1'b1, 8'h21, S, 8'h00, 1'b0);
      host_xfer("c char", 1'b1, 8'h22, S, 8'h00, 1'b0);
      host_xfer("display on", 1'b0, 8'h0C, S, 8'h00, 1'b0);
      check_cursor("after 0x0C", 1'b0, 4'd2);

      // Reset in WAIT: outputs clear at once, full init reruns
      check("pre-reset ready", ready, 1);
      req      = 1'b1;
      req_rs   = 1'b1;
      req_data = 8'h55;
      tick();
      req = 1'b0;
      wait_intr("pre-reset", w);
      tick();
      rst = 1'b1;
      #1;
      check("mid rst ready", ready, 0);
      check("mid rst init_done", init_done, 0);
      check("mid rst intr", lcd_intr, 0);
      check("mid rst din", lcd_din, 0);
      check_cursor("mid rst", 1'b0, 4'd0);
      tick();
      rst = 1'b0;
      run_init("reinit");
      host_xfer("after reinit", 1'b1, 8'h41, S, 8'h00, 1'b0);
      check_cursor("after reinit", 1'b0, 4'd1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/lcd_sequencer.md
# lcd_sequencer

Command sequencer in front of the LCD write engine. After reset it waits out the HD44780 power-up time, then issues the fixed four-command init sequence. It then accepts single command/character requests from a host and forwards each to the write engine with the correct post-write delay. It also tracks the cursor on a 16x2 panel and inserts a DDRAM-address command automatically at each line end.

## Interface
- PWRUP_CYC, 331776: power-up wait in clocks (15 ms at 22.1184 MHz); 19-bit counter.
- DLY_SHORT, 885: post-write delay for ordinary writes (40 us); placed in din[25:9].
- DLY_LONG, 36275: post-write delay for clear (0x01) and home (0x02) commands (1.64 ms).
- COLS, 16: characters per line.
- clk  in  1  main clock, 22.1184 MHz.
- rst  in  1  asynchronous, active-high reset.
- req  in  1  host request; accepted when req && ready.
- req_rs  in  1  0 = command, 1 = character data.
- req_data  in  8  command/character byte.
- ready  out  1  sequencer idle and able to accept a request.
- init_done  out  1  init sequence complete; stays high until reset.
- lcd_intr  out  1  one-cycle start pulse to the write engine.
- lcd_din  out  26  {17-bit delay, rs, 8-bit data} to the write engine.
- lcd_ok  in  1  one-cycle completion pulse from the write engine.

## Operation
- States: PWRUP, INIT, IDLE, SEND, WAIT, WRAP.
- PWRUP: count 0..PWRUP_CYC-1, then go to INIT with init index 0.
- INIT: load lcd_din from the init ROM at the current index:
  - 0x38 (function set)
  - 0x0C (display on)
  - 0x01 (clear, DLY_LONG)
  - 0x06 (entry mode)
  - All use rs=0; all except clear use DLY_SHORT.
  - Then SEND. After the 4th ok, set init_done, clear the cursor (line 0, col 0) and go to IDLE.
- IDLE: ready=1. On accept, latch {delay, req_rs, req_data} into lcd_din and go to SEND.
  - Delay selection: DLY_LONG if req_rs=0 and req_data is 0x01 or 0x02; otherwise DLY_SHORT.
- SEND: lcd_intr=1 for exactly this cycle, then WAIT.
- WAIT: hold lcd_din stable. The engine samples rs and data combinationally until it finishes, so lcd_din must not change before lcd_ok. On lcd_ok:
  - During init: advance the init index and go to INIT, or go to IDLE after the last entry.
  - Character write: col+1. If col was COLS-1, set col=0, toggle line, go to WRAP. Otherwise go to IDLE.
  - Command 0x01 or 0x02: cursor to line 0, col 0; go to IDLE.
  - Command with bit7=1 (set DDRAM address): line = data[6], col = data[3:0]; go to IDLE.
  - Any other command: cursor unchanged; go to IDLE.
- WRAP: load lcd_din = {DLY_SHORT, 0, line ? 0xC0 : 0x80}, go to SEND. On its ok, go to IDLE with no cursor update.
- lcd_ok outside WAIT is ignored. The engine emits one ok as it leaves reset.

## Timing
- Reset values: ready=0, init_done=0, lcd_intr=0, lcd_din=0, state=PWRUP, cursor=0.
- Accept in cycle N means lcd_intr=1 in cycle N+1. ready is 0 from N+1 until the cycle after lcd_ok.
- lcd_ok in cycle M: IDLE with ready=1 at M+1, or WRAP at M+1 and lcd_intr at M+2.
- Back-to-back requests: at most one accept per transaction. req held high while ready=0 is not queued.
- All parameter delays must be ≥3, because the engine completes at delay-2.
- Reset mid-transaction: return immediately to PWRUP and rerun the full init.
- Simultaneous req and a pending wrap cannot occur, because ready=0 throughout WAIT and WRAP.

## Structure
- Shared package `lcd_pkg`:
  - state encodings
  - init ROM contents (4 × 9-bit {rs, data})
  - command codes CLEAR=0x01, HOME=0x02, LINE0=0x80, LINE1=0xC0
  - the 26-bit din field layout
- The init ROM is a case-based function in the package, not a sub-module.
- Sub-module `lcd_cursor` (col/line counter with load, clear and wrap output) is natural. Top instantiates it together with the existing write engine in the display top level.

## Test plan
- Reset release: the first lcd_intr occurs at exactly PWRUP_CYC+1 cycles. din values in order are {885,0,0x38}, {885,0,0x0C}, {36275,0,0x01}, {885,0,0x06}; init_done=1 after the 4th ok.
- After init, host char 0x41 with rs=1 → lcd_din={885,1,0x41}, ready returns the cycle after ok, col=1.
- 16 consecutive characters → the 16th is followed by an automatic {885,0,0xC0} write before ready; after a further 16, {885,0,0x80} is written.
- Command 0x01 mid-line → delay field 36275, cursor resets; the next 16 characters wrap to 0xC0.
- Command 0xC5 → cursor at line 1, col 5; after 11 characters, wrap to 0x80.
- Assert rst during WAIT → all outputs at reset values next cycle; the full init sequence reruns; spurious ok pulses before WAIT are ignored.
